gpio_bank: RTL and testbench

- Parametrised successor to the fixed two-port GPIO section of the CPU I/O block.
- Provides NCH independent channels of W bits each. Every channel has:
  - per-bit direction control
  - atomic set, clear and toggle of the output register
  - a 2-flop input synchroniser
  - rising/falling edge detection with a sticky, write-1-to-clear status register
- All channels share one combined interrupt line.
- Sits on the CPU I/O bus (CS/write/adresse/DATAout/DATAin) next to the SPI and UART peripherals.

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_channel.sv | 103 ++++++++++
 rtl/gpio_bank.sv | 98 +++++++++
 tb/tb_gpio_bank.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register offsets inside one channel
// window and the address stride between channel windows.
package gpio_pkg;

  localparam logic [3:0] OFF_IN   = 4'd0;
  localparam logic [3:0] OFF_OUT  = 4'd1;
  localparam logic [3:0] OFF_SET  = 4'd2;
  localparam logic [3:0] OFF_CLR  = 4'd3;
  localparam logic [3:0] OFF_TGL  = 4'd4;
  localparam logic [3:0] OFF_DIR  = 4'd5;
  localparam logic [3:0] OFF_REN  = 4'd6;
  localparam logic [3:0] OFF_FEN  = 4'd7;
  localparam logic [3:0] OFF_STAT = 4'd8;

  localparam int unsigned CH_STRIDE = 16;

endpackage

// File: rtl/gpio_channel.sv
// One GPIO channel: OUT/DIR/REN/FEN/STAT registers, a two-flop pad
// synchroniser, rise/fall edge detection and the register read mux.
// State advances on the falling clock edge to match the CPU bus timing.
module gpio_channel
  import gpio_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic         write,
  input  logic [3:0]   offset,
  input  logic [W-1:0] d,
  input  logic [W-1:0] pin,
  output logic [W-1:0] rdata,
  output logic [W-1:0] out,
  output logic [W-1:0] oe,
  output logic         stat_any
);

  logic [W-1:0] out_q, out_d;
  logic [W-1:0] dir_q, dir_d;
  logic [W-1:0] ren_q, ren_d;
  logic [W-1:0] fen_q, fen_d;
  logic [W-1:0] stat_q, stat_d;
  logic [W-1:0] sync1_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;
  logic [W-1:0] clr_s;
  logic [W-1:0] rise_s;
  logic [W-1:0] fall_s;

  // Next-state for the CPU-writable registers and the sticky status;
  // a fresh edge overrides a write-1-to-clear on the same bit.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    ren_d = ren_q;
    fen_d = fen_q;
    clr_s = '0;
    if (sel && write) begin
      case (offset)
        OFF_OUT:  out_d = d;
        OFF_SET:  out_d = out_q | d;
        OFF_CLR:  out_d = out_q & ~d;
        OFF_TGL:  out_d = out_q ^ d;
        OFF_DIR:  dir_d = d;
        OFF_REN:  ren_d = d;
        OFF_FEN:  fen_d = d;
        OFF_STAT: clr_s = d;
        default:  clr_s = '0;
      endcase
    end else begin
      clr_s = '0;
    end
    rise_s = sync_q & ~prev_q & ren_q;
    fall_s = ~sync_q & prev_q & fen_q;
    stat_d = (stat_q & ~clr_s) | rise_s | fall_s;
  end

  // Register bank, synchroniser chain and previous-sample flop.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      dir_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      stat_q  <= '0;
      sync1_q <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      stat_q  <= stat_d;
      sync1_q <= pin;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  // Read mux; write-only and reserved offsets read as zero.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_IN:   rdata = sync_q;
      OFF_OUT:  rdata = out_q;
      OFF_DIR:  rdata = dir_q;
      OFF_REN:  rdata = ren_q;
      OFF_FEN:  rdata = fen_q;
      OFF_STAT: rdata = stat_q;
      default:  rdata = '0;
    endcase
  end

  assign out      = out_q;
  assign oe       = dir_q;
  assign stat_any = |stat_q;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank on the CPU I/O bus: decodes a 16-word window per channel,
// instantiates NCH channels, registers read data and ORs all status
// bits into one interrupt line.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int          NCH  = 2,
  parameter int          W    = 8,
  parameter logic [13:0] BASE = 14'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CS,
  input  logic             write,
  input  logic [13:0]      adresse,
  input  logic [15:0]      DATAout,
  output logic [15:0]      DATAin,
  input  logic [NCH*W-1:0] gpio_in,
  output logic [NCH*W-1:0] gpio_out,
  output logic [NCH*W-1:0] gpio_oe,
  output logic             irq
);

  // Width of the whole block in words, one bit wider than the bus address
  // so a block ending at the top of the address space still compares.
  localparam logic [14:0] SPAN = 15'(NCH * CH_STRIDE);

  logic [13:0]   rel_s;
  logic          hit_s;
  logic [W-1:0]  d_s;
  logic [NCH-1:0] sel_s;
  logic [NCH-1:0] stat_any_s;
  logic [W-1:0]  rdata_s [NCH];
  logic [W-1:0]  rd_or_s;
  logic [15:0]   datain_q, datain_d;
  logic          unused_data_s;

  assign rel_s = adresse - BASE;
  assign hit_s = CS && (adresse >= BASE) && ({1'b0, rel_s} < SPAN);
  assign d_s   = DATAout[W-1:0];
  // Upper data bits beyond the channel width are deliberately ignored.
  assign unused_data_s = ^DATAout;

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign sel_s[c] = hit_s && (rel_s[13:4] == 10'(c));

      gpio_channel #(.W(W)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel_s[c]),
        .write    (write),
        .offset   (rel_s[3:0]),
        .d        (d_s),
        .pin      (gpio_in[c*W +: W]),
        .rdata    (rdata_s[c]),
        .out      (gpio_out[c*W +: W]),
        .oe       (gpio_oe[c*W +: W]),
        .stat_any (stat_any_s[c])
      );
    end
  endgenerate

  // Merge the selected channel's read data; at most one channel is selected.
  always_comb begin
    rd_or_s = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_s[c]) begin
        rd_or_s = rd_or_s | rdata_s[c];
      end else begin
        rd_or_s = rd_or_s;
      end
    end
  end

  // Read data is zero unless this is a read hit, since the bus is OR-combined.
  always_comb begin
    datain_d = 16'h0000;
    if (hit_s && !write) begin
      datain_d = 16'(rd_or_s);
    end else begin
      datain_d = 16'h0000;
    end
  end

  // Registered read data towards the CPU.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      datain_q <= 16'h0000;
    end else begin
      datain_q <= datain_d;
    end
  end

  assign DATAin = datain_q;
  assign irq    = |stat_any_s;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios plus randomized
// register traffic and pad activity against a register-level model.
module tb_gpio_bank;

  localparam int          NCH  = 2;
  localparam int          W    = 8;
  localparam logic [13:0] BASE = 14'd16;
  localparam int          NB   = NCH * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          CS = 1'b0;
  logic          write = 1'b0;
  logic [13:0]   adresse = 14'd0;
  logic [15:0]   DATAout = 16'h0000;
  logic [15:0]   DATAin;
  logic [NB-1:0] gpio_in = '0;
  logic [NB-1:0] gpio_out;
  logic [NB-1:0] gpio_oe;
  logic          irq;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  m_out [NCH];
  logic [W-1:0]  m_dir [NCH];
  logic [W-1:0]  m_ren [NCH];
  logic [W-1:0]  m_fen [NCH];
  logic [W-1:0]  m_stat[NCH];
  logic [NB-1:0] m_pins;

  always #5 clk = ~clk;

  gpio_bank #(.NCH(NCH), .W(W), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .CS(CS), .write(write), .adresse(adresse),
    .DATAout(DATAout), .DATAin(DATAin), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_out[c] = '0; m_dir[c] = '0; m_ren[c] = '0; m_fen[c] = '0; m_stat[c] = '0;
    end
  endtask

  function automatic logic is_hit(input logic cs, input logic [13:0] a);
    return cs && (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 16 * NCH);
  endfunction

  task automatic model_write(input int c, input int off, input logic [15:0] d16);
    logic [W-1:0] d;
    d = d16[W-1:0];
    case (off)
      1: m_out[c] = d;
      2: m_out[c] = m_out[c] | d;
      3: m_out[c] = m_out[c] & ~d;
      4: m_out[c] = m_out[c] ^ d;
      5: m_dir[c] = d;
      6: m_ren[c] = d;
      7: m_fen[c] = d;
      8: m_stat[c] = m_stat[c] & ~d;
      default: ;
    endcase
  endtask

  function automatic logic [15:0] model_read(input int c, input int off);
    case (off)
      0: return 16'(m_pins[c*W +: W]);
      1: return 16'(m_out[c]);
      5: return 16'(m_dir[c]);
      6: return 16'(m_ren[c]);
      7: return 16'(m_fen[c]);
      8: return 16'(m_stat[c]);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exp_read(input logic cs, input logic [13:0] a);
    int r;
    r = int'(a) - int'(BASE);
    if (!is_hit(cs, a)) return 16'h0000;
    return model_read(r / 16, r % 16);
  endfunction

  function automatic logic [NB-1:0] exp_out();
    logic [NB-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*W +: W] = m_out[c];
    return v;
  endfunction

  function automatic logic [NB-1:0] exp_oe();
    logic [NB-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*W +: W] = m_dir[c];
    return v;
  endfunction

  function automatic logic exp_irq();
    logic v;
    v = 1'b0;
    for (int c = 0; c < NCH; c++) v = v | (|m_stat[c]);
    return v;
  endfunction

  // Pads moved from m_pins to p: every enabled rise/fall latches in STAT.
  task automatic model_pins(input logic [NB-1:0] p);
    logic [W-1:0] o, n;
    for (int c = 0; c < NCH; c++) begin
      o = m_pins[c*W +: W];
      n = p[c*W +: W];
      m_stat[c] = m_stat[c] | (n & ~o & m_ren[c]) | (~n & o & m_fen[c]);
    end
    m_pins = p;
  endtask

  // ---------------- bus / pad drivers ----------------
  task automatic bus_write(input logic cs, input logic [13:0] a, input logic [15:0] d);
    int r;
    @(posedge clk);
    CS = cs; write = 1'b1; adresse = a; DATAout = d;
    @(negedge clk);
    #1;
    CS = 1'b0; write = 1'b0;
    r = int'(a) - int'(BASE);
    if (is_hit(cs, a)) model_write(r / 16, r % 16, d);
  endtask

  task automatic bus_read(input logic cs, input logic [13:0] a, output logic [15:0] q);
    @(posedge clk);
    CS = cs; write = 1'b0; adresse = a;
    @(negedge clk);
    #1;
    q = DATAin;
    CS = 1'b0;
  endtask

  task automatic apply_pins(input logic [NB-1:0] p);
    @(posedge clk);
    gpio_in = p;
    repeat (4) @(negedge clk);
    #1;
    model_pins(p);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] q;
    gpio_in = '1;
    model_reset();
    #2;
    checks++; if (gpio_out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", gpio_out); end
    checks++; if (gpio_oe !== '0) begin errors++; $display("FAIL reset_oe: got %h expected 0", gpio_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (DATAin !== 16'h0000) begin errors++; $display("FAIL reset_datain: got %h expected 0000", DATAin); end
    @(posedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    m_pins = '1;
    bus_read(1'b1, BASE, q);
    checks++; if (q !== 16'h00FF) begin errors++; $display("FAIL reset_in_ch0: got %h expected 00FF", q); end
    bus_read(1'b1, BASE + 14'd16, q);
    checks++; if (q !== 16'h00FF) begin errors++; $display("FAIL reset_in_ch1: got %h expected 00FF", q); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_no_edge_latch: irq got %b expected 0", irq); end
  endtask

  task automatic test_out_ops();
    logic [3:0]  offs [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [7:0]  dats [4] = '{8'hA5, 8'h0A, 8'h80, 8'hFF};
    logic [7:0]  exps [4] = '{8'hA5, 8'hAF, 8'h2F, 8'hD0};
    logic [15:0] q;
    for (int i = 0; i < 4; i++) begin
      bus_write(1'b1, BASE + 14'(offs[i]), {8'h00, dats[i]});
      checks++; if (gpio_out[7:0] !== exps[i]) begin errors++; $display("FAIL out_pin step %0d: got %h expected %h", i, gpio_out[7:0], exps[i]); end
      bus_read(1'b1, BASE + 14'd1, q);
      checks++; if (q !== {8'h00, exps[i]}) begin errors++; $display("FAIL out_read step %0d: got %h expected %h", i, q, {8'h00, exps[i]}); end
    end
  endtask

  task automatic test_dir_reserved();
    logic [15:0] q;
    bus_write(1'b1, BASE + 14'd21, 16'hFF0F);
    checks++; if (gpio_oe !== 16'h0F00) begin errors++; $display("FAIL dir_ch1: got %h expected 0F00", gpio_oe); end
    bus_read(1'b1, BASE + 14'd21, q);
    checks++; if (q !== 16'h000F) begin errors++; $display("FAIL dir_read: got %h expected 000F", q); end
    bus_write(1'b1, BASE + 14'd25, 16'hFFFF);
    bus_read(1'b1, BASE + 14'd25, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL reserved_read: got %h expected 0000", q); end
    bus_read(1'b1, BASE + 14'd2, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL set_read: got %h expected 0000", q); end
    checks++; if (gpio_out !== exp_out()) begin errors++; $display("FAIL reserved_side_effect: got %h expected %h", gpio_out, exp_out()); end
  endtask

  task automatic test_miss();
    logic [15:0] q;
    bus_write(1'b0, BASE + 14'd1, 16'h0033);
    bus_write(1'b1, BASE - 14'd1, 16'h00FF);
    bus_write(1'b1, BASE + 14'(16 * NCH), 16'h00FF);
    bus_write(1'b1, BASE + 14'(16 * NCH + 5), 16'h00FF);
    checks++; if (gpio_out !== exp_out()) begin errors++; $display("FAIL miss_out: got %h expected %h", gpio_out, exp_out()); end
    checks++; if (gpio_oe !== exp_oe()) begin errors++; $display("FAIL miss_oe: got %h expected %h", gpio_oe, exp_oe()); end
    bus_read(1'b0, BASE + 14'd1, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL miss_cs_read: got %h expected 0000", q); end
    bus_read(1'b1, BASE + 14'(16 * NCH + 1), q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL miss_addr_read: got %h expected 0000", q); end
  endtask

  task automatic test_random_regs();
    logic [15:0] q, e, d;
    logic [13:0] a;
    logic        cs;
    int          kind;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      cs   = 1'b1;
      a    = BASE + 14'($urandom_range(0, NCH - 1) * 16 + $urandom_range(0, 15));
      d    = 16'($urandom);
      if (kind == 8) cs = 1'b0;
      if (kind == 9) begin
        if ($urandom_range(0, 1) == 0) a = BASE - 14'($urandom_range(1, 16));
        else a = BASE + 14'(16 * NCH + $urandom_range(0, 100));
      end
      if (kind < 4 || kind >= 8) begin
        bus_write(cs, a, d);
        checks++; if (DATAin !== 16'h0000) begin errors++; $display("FAIL rnd_write_datain it %0d: got %h expected 0000", i, DATAin); end
      end
      if (kind >= 4) begin
        e = exp_read(cs, a);
        bus_read(cs, a, q);
        checks++; if (q !== e) begin errors++; $display("FAIL rnd_read it %0d addr %0d: got %h expected %h", i, a, q, e); end
      end
      checks++; if (gpio_out !== exp_out()) begin errors++; $display("FAIL rnd_out it %0d: got %h expected %h", i, gpio_out, exp_out()); end
      checks++; if (gpio_oe !== exp_oe()) begin errors++; $display("FAIL rnd_oe it %0d: got %h expected %h", i, gpio_oe, exp_oe()); end
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rnd_irq it %0d: got %b expected %b", i, irq, exp_irq()); end
    end
  endtask

  task automatic test_edges();
    logic [15:0] q;
    logic        seen;
    for (int c = 0; c < NCH; c++) begin
      bus_write(1'b1, BASE + 14'(c * 16 + 6), 16'h0000);
      bus_write(1'b1, BASE + 14'(c * 16 + 7), 16'h0000);
    end
    apply_pins('0);
    for (int c = 0; c < NCH; c++) bus_write(1'b1, BASE + 14'(c * 16 + 8), 16'hFFFF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_pre_irq: got %b expected 0", irq); end
    bus_write(1'b1, BASE + 14'd6, 16'h0001);
    @(posedge clk);
    gpio_in = NB'(1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (irq === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL edge_rise_irq: got %b expected 1 within 3 clocks", seen); end
    repeat (2) @(negedge clk);
    model_pins(NB'(1));
    bus_read(1'b1, BASE + 14'd8, q);
    checks++; if (q !== 16'h0001) begin errors++; $display("FAIL edge_rise_stat: got %h expected 0001", q); end
    bus_write(1'b1, BASE + 14'd8, 16'h0001);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_w1c_irq: got %b expected 0", irq); end
    apply_pins('0);
    bus_read(1'b1, BASE + 14'd8, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL edge_fall_masked: got %h expected 0000", q); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_fall_irq: got %b expected 0", irq); end
  endtask

  task automatic test_random_edges();
    logic [15:0] q, e;
    logic [NB-1:0] p;
    for (int c = 0; c < NCH; c++) begin
      bus_write(1'b1, BASE + 14'(c * 16 + 6), 16'($urandom));
      bus_write(1'b1, BASE + 14'(c * 16 + 7), 16'($urandom));
    end
    for (int i = 0; i < 24; i++) begin
      p = NB'($urandom);
      apply_pins(p);
      for (int c = 0; c < NCH; c++) begin
        e = model_read(c, 8);
        bus_read(1'b1, BASE + 14'(c * 16 + 8), q);
        checks++; if (q !== e) begin errors++; $display("FAIL rnd_stat it %0d ch %0d: got %h expected %h", i, c, q, e); end
        e = model_read(c, 0);
        bus_read(1'b1, BASE + 14'(c * 16), q);
        checks++; if (q !== e) begin errors++; $display("FAIL rnd_in it %0d ch %0d: got %h expected %h", i, c, q, e); end
      end
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rnd_edge_irq it %0d: got %b expected %b", i, irq, exp_irq()); end
      if (i % 3 == 2) begin
        bus_write(1'b1, BASE + 14'($urandom_range(0, NCH - 1) * 16 + 8), 16'($urandom));
        checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rnd_w1c_irq it %0d: got %b expected %b", i, irq, exp_irq()); end
      end
    end
  endtask

  task automatic test_w1c_collision();
    logic [15:0] q;
    for (int c = 0; c < NCH; c++) begin
      bus_write(1'b1, BASE + 14'(c * 16 + 6), 16'h0000);
      bus_write(1'b1, BASE + 14'(c * 16 + 7), 16'h0000);
    end
    apply_pins('0);
    for (int c = 0; c < NCH; c++) bus_write(1'b1, BASE + 14'(c * 16 + 8), 16'hFFFF);
    bus_write(1'b1, BASE + 14'd6, 16'h0001);
    apply_pins(NB'(1));
    apply_pins('0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_pre_irq: got %b expected 1", irq); end
    @(posedge clk);
    gpio_in = NB'(1);
    @(negedge clk);
    @(negedge clk);
    bus_write(1'b1, BASE + 14'd8, 16'h0001);
    model_pins(NB'(1));
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq: got %b expected 1", irq); end
    bus_read(1'b1, BASE + 14'd8, q);
    checks++; if (q !== 16'h0001) begin errors++; $display("FAIL coll_stat: got %h expected 0001", q); end
  endtask

  task automatic test_async_reset();
    logic [15:0] q;
    bus_write(1'b1, BASE + 14'd1, 16'h00FF);
    bus_write(1'b1, BASE + 14'd6, 16'h0003);
    apply_pins('0);
    bus_write(1'b1, BASE + 14'd8, 16'hFFFF);
    apply_pins(NB'(3));
    bus_read(1'b1, BASE + 14'd8, q);
    checks++; if (q !== 16'h0003) begin errors++; $display("FAIL ares_pre_stat: got %h expected 0003", q); end
    @(posedge clk);
    CS = 1'b1; write = 1'b1; adresse = BASE + 14'd1; DATAout = 16'h0055;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (gpio_out !== '0) begin errors++; $display("FAIL ares_out: got %h expected 0", gpio_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ares_irq: got %b expected 0", irq); end
    checks++; if (DATAin !== 16'h0000) begin errors++; $display("FAIL ares_datain: got %h expected 0000", DATAin); end
    @(negedge clk); #1;
    CS = 1'b0; write = 1'b0;
    @(posedge clk); rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    bus_read(1'b1, BASE + 14'd1, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL ares_out_read: got %h expected 0000", q); end
    bus_read(1'b1, BASE + 14'd8, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL ares_stat_read: got %h expected 0000", q); end
  endtask

  initial begin
    test_reset();
    test_out_ops();
    test_dir_reserved();
    test_miss();
    test_random_regs();
    test_edges();
    test_random_edges();
    test_w1c_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
